// File: rtl/matvec_accumulator_if.sv
// Bus between the matrix-vector accumulator, its controller and the weightRAM.
//   start       : request a new product (controller -> accumulator)
//   inputVector : x, packed NCOLS words of BITWIDTH bits
//   weightAddr  : column address to weightRAM (accumulator -> RAM)
//   weightCol   : packed column from weightRAM, one cycle after its address
//   busy, done  : status; done is a one-cycle pulse with result valid
//   result      : y, packed NROWS words of BITWIDTH bits
// The slave modport is the accumulator side; master is the controller/RAM side.
interface matvec_accumulator_if #(
  parameter int BITWIDTH   = 18,
  parameter int NROWS      = 16,
  parameter int NCOLS      = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                          start;
  logic [NCOLS*BITWIDTH-1:0]     inputVector;
  logic [ADDR_WIDTH-1:0]         weightAddr;
  logic [NROWS*BITWIDTH-1:0]     weightCol;
  logic                          busy;
  logic                          done;
  logic [NROWS*BITWIDTH-1:0]     result;

  modport master (
    output start, inputVector, weightCol,
    input  weightAddr, busy, done, result
  );

  modport slave (
    input  start, inputVector, weightCol,
    output weightAddr, busy, done, result
  );
endinterface

// File: rtl/matvec_accumulator.sv
// Matrix-vector accumulator: computes y = W*x for one recurrent layer.
// Walks the weightRAM column addresses, multiplies each returned column by the
// matching latched x[j] and accumulates into NROWS full-precision accumulators.
// The result is shifted down by FRACBITS (floor), saturated to BITWIDTH and
// presented with a one-cycle done pulse.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : matvec_accumulator_if.slave (start, inputVector, weightAddr,
//           weightCol, busy, done, result)
module matvec_accumulator #(
  parameter int BITWIDTH   = 18,
  parameter int FRACBITS   = 14,
  parameter int NROWS      = 16,
  parameter int NCOLS      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input logic                  clock,
  input logic                  reset,
  matvec_accumulator_if.slave  bus
);

  localparam int ACCW = 2*BITWIDTH + ADDR_WIDTH;
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(2**(BITWIDTH-1) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]          col_q, col_d;
  logic                           valid_q, valid_d;
  logic [NCOLS*BITWIDTH-1:0]      x_q, x_d;
  logic signed [ACCW-1:0]         acc_q [NROWS];
  logic signed [ACCW-1:0]         acc_d [NROWS];
  logic [NROWS*BITWIDTH-1:0]      result_q, result_d;
  logic                           done_q, done_d;
  logic                           busy_q, busy_d;

  logic signed [BITWIDTH-1:0]     x_sel;
  logic signed [2*BITWIDTH-1:0]   prod [NROWS];
  logic                           accept;

  function automatic logic [BITWIDTH-1:0] sat_out(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> FRACBITS;
    if (s > SAT_MAX)      return SAT_MAX[BITWIDTH-1:0];
    else if (s < SAT_MIN) return SAT_MIN[BITWIDTH-1:0];
    else                  return s[BITWIDTH-1:0];
  endfunction

  // col_q tags which column is currently on weightCol (address of the previous cycle).
  assign x_sel  = $signed(x_q[int'(col_q)*BITWIDTH +: BITWIDTH]);
  assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    for (int unsigned i = 0; i < NROWS; i++) begin
      prod[i] = $signed(bus.weightCol[i*BITWIDTH +: BITWIDTH]) * x_sel;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    col_d    = cnt_q;
    valid_d  = (state_q == RUN);
    x_d      = x_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;

    if (valid_q) begin
      for (int unsigned i = 0; i < NROWS; i++) begin
        acc_d[i] = acc_q[i] + ACCW'(prod[i]);
      end
    end

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (accept) begin
          x_d     = bus.inputVector;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
          for (int unsigned i = 0; i < NROWS; i++) begin
            acc_d[i] = '0;
          end
        end
      end
      RUN: begin
        if (cnt_q == ADDR_WIDTH'(NCOLS - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // Final column is folded in on this edge, so the result is taken from
        // the updated accumulator value to have it valid in the DONE cycle.
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        for (int unsigned i = 0; i < NROWS; i++) begin
          result_d[i*BITWIDTH +: BITWIDTH] = sat_out(acc_d[i]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      col_q    <= '0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      acc_q    <= '{default: '0};
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.weightAddr = cnt_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;

endmodule
